// File: rtl/inst_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Optional step mode is selected with the INST_SEQ_STEP_MODE_EN macro.
package inst_seq_pkg;

  localparam int unsigned INST_W = 20;
  localparam int unsigned RES_W  = 32;

  // Instruction word fields, kept for debug views and layout checks
  localparam int unsigned OP_HI  = 19;
  localparam int unsigned OP_LO  = 18;
  localparam int unsigned DST_HI = 17;
  localparam int unsigned DST_LO = 13;
  localparam int unsigned FN_HI  = 12;
  localparam int unsigned FN_LO  = 10;
  localparam int unsigned SRA_HI = 9;
  localparam int unsigned SRA_LO = 5;
  localparam int unsigned SRB_HI = 4;
  localparam int unsigned SRB_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_OUT  = 3'd2,
    S_DONE = 3'd3
`ifdef INST_SEQ_STEP_MODE_EN
    ,
    S_HOLD = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/inst_seq_pmem.sv
// Program buffer: DEPTH x INST_W registers, one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module inst_seq_pmem
  import inst_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata_c
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/inst_seq_ctrl.sv
// Program sequencer: issues buffered instructions to the datapath, waits LAT
// cycles, and hands each result out on a valid/ready port. INST_SEQ_STEP_MODE_EN adds step.
module inst_seq_ctrl
  import inst_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [INST_W-1:0] load_data,
  input  logic [AW:0]       prog_len,
  input  logic              start,
`ifdef INST_SEQ_STEP_MODE_EN
  input  logic              step,
`endif
  output logic              busy,
  output logic              done,
  output logic [INST_W-1:0] instruccion,
  output logic              inst_valid,
  input  logic [RES_W-1:0]  alu_result,
  output logic              res_valid,
  output logic [RES_W-1:0]  res_data,
  output logic [AW-1:0]     res_idx,
  input  logic              res_ready
);

  localparam int unsigned   CW       = 3;
  localparam logic [AW:0]   MAX_LEN  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  // Elaboration-time sanity checks on parameters and the instruction layout
  if ((LAT == 0) || (LAT > 7)) begin : g_bad_lat
    $error("inst_seq_ctrl: LAT must be in 1..7");
  end
  if (DEPTH != (2 ** AW)) begin : g_bad_depth
    $error("inst_seq_ctrl: DEPTH must equal 2**AW");
  end
  if ((OP_HI != INST_W - 1) || (OP_LO != DST_HI + 1) || (DST_LO != FN_HI + 1) ||
      (FN_LO != SRA_HI + 1) || (SRA_LO != SRB_HI + 1) || (SRB_LO != 0)) begin : g_bad_fields
    $error("inst_seq_ctrl: instruction fields do not tile INST_W");
  end

  state_e            state, state_d;
  logic [AW-1:0]     pc, pc_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [AW:0]       len, len_d;
  logic              busy_d, done_d, inst_valid_d, res_valid_d;
  logic [INST_W-1:0] instruccion_d;
  logic [RES_W-1:0]  res_data_d;
  logic [AW-1:0]     res_idx_d;
  logic [AW-1:0]     mem_raddr_c;
  logic [INST_W-1:0] mem_rdata_c;
  logic              mem_we_c, last_c, advance_c;

  // Read port points at entry 0 while idle, otherwise at the next entry
  assign mem_raddr_c = (state == S_IDLE) ? '0 : pc + AW'(1);
  assign mem_we_c    = load_we && (state == S_IDLE);
  assign last_c      = ({1'b0, pc} == (len - (AW+1)'(1)));

  inst_seq_pmem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_pmem (
    .clk     (clk),
    .we      (mem_we_c),
    .waddr   (load_addr),
    .wdata   (load_data),
    .raddr   (mem_raddr_c),
    .rdata_c (mem_rdata_c)
  );

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    cnt_d         = cnt;
    len_d         = len;
    busy_d        = busy;
    done_d        = 1'b0;
    instruccion_d = instruccion;
    inst_valid_d  = inst_valid;
    res_valid_d   = res_valid;
    res_data_d    = res_data;
    res_idx_d     = res_idx;
    advance_c     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (prog_len == '0) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            len_d         = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
            pc_d          = '0;
            instruccion_d = mem_rdata_c;
            inst_valid_d  = 1'b1;
            busy_d        = 1'b1;
            cnt_d         = CNT_INIT;
            state_d       = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          res_data_d  = alu_result;
          res_idx_d   = pc;
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (last_c) begin
            inst_valid_d = 1'b0;
            done_d       = 1'b1;
            state_d      = S_DONE;
          end else begin
`ifdef INST_SEQ_STEP_MODE_EN
            state_d = S_HOLD;
`else
            advance_c = 1'b1;
`endif
          end
        end
      end
`ifdef INST_SEQ_STEP_MODE_EN
      S_HOLD: advance_c = step;
`endif
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Issue the following entry; pc never wraps because last_c stops the run
    if (advance_c) begin
      pc_d          = pc + AW'(1);
      instruccion_d = mem_rdata_c;
      cnt_d         = CNT_INIT;
      state_d       = S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      cnt         <= '0;
      len         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      instruccion <= '0;
      inst_valid  <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_idx     <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      cnt         <= cnt_d;
      len         <= len_d;
      busy        <= busy_d;
      done        <= done_d;
      instruccion <= instruccion_d;
      inst_valid  <= inst_valid_d;
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
      res_idx     <= res_idx_d;
    end
  end

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Directed bench for inst_seq_ctrl: two instances (LAT=1 and LAT=3) share
// stimulus; each has a pass-through datapath model alu_result = {12'h0, instruccion}.
`timescale 1ns/1ps
module tb_inst_seq_ctrl;
  import inst_seq_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic              load_we   = 1'b0;
  logic [AW-1:0]     load_addr = '0;
  logic [INST_W-1:0] load_data = '0;
  logic [AW:0]       prog_len  = '0;
  logic              start     = 1'b0;
  logic              res_ready = 1'b1;
`ifdef INST_SEQ_STEP_MODE_EN
  logic              step      = 1'b1;
`endif

  logic              d1_busy, d1_done, d1_iv, d1_rv, d3_busy, d3_done, d3_iv, d3_rv;
  logic [INST_W-1:0] d1_inst, d3_inst;
  logic [RES_W-1:0]  d1_data, d3_data, d1_alu, d3_alu;
  logic [AW-1:0]     d1_idx, d3_idx;

  assign d1_alu = {12'h0, d1_inst};
  assign d3_alu = {12'h0, d3_inst};

  always #5 clk = ~clk;

  inst_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start),
`ifdef INST_SEQ_STEP_MODE_EN
    .step(step),
`endif
    .busy(d1_busy), .done(d1_done), .instruccion(d1_inst), .inst_valid(d1_iv),
    .alu_result(d1_alu), .res_valid(d1_rv), .res_data(d1_data), .res_idx(d1_idx),
    .res_ready(res_ready)
  );

  inst_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start),
`ifdef INST_SEQ_STEP_MODE_EN
    .step(step),
`endif
    .busy(d3_busy), .done(d3_done), .instruccion(d3_inst), .inst_valid(d3_iv),
    .alu_result(d3_alu), .res_valid(d3_rv), .res_data(d3_data), .res_idx(d3_idx),
    .res_ready(res_ready)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [INST_W-1:0] model_mem [DEPTH];

  // Monitor state, written only by the monitor process
  logic [RES_W-1:0]  got_data [2][512];
  logic [AW-1:0]     got_idx  [2][512];
  int n_got[2]     = '{0, 0};
  int n_done[2]    = '{0, 0};
  int n_lat[2]     = '{0, 0};
  int n_latbad[2]  = '{0, 0};
  int bad_lat[2]   = '{0, 0};
  int n_iv[2]      = '{0, 0};
  int n_rv[2]      = '{0, 0};
  int done_cyc[2]  = '{0, 0};
  int issue_cyc[2] = '{0, 0};
  logic prev_rv[2] = '{1'b0, 1'b0};
  logic prev_iv[2] = '{1'b0, 1'b0};
  logic [INST_W-1:0] prev_inst[2] = '{20'h0, 20'h0};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sample both DUTs mid-cycle; cyc then names the edge that produced the values
  initial forever begin
    logic rv [2];
    logic iv [2];
    logic dn [2];
    logic [INST_W-1:0] ins [2];
    logic [RES_W-1:0]  dat [2];
    logic [AW-1:0]     idx [2];
    @(negedge clk);
    #1;
    rv[0] = d1_rv;   rv[1] = d3_rv;
    iv[0] = d1_iv;   iv[1] = d3_iv;
    dn[0] = d1_done; dn[1] = d3_done;
    ins[0] = d1_inst; ins[1] = d3_inst;
    dat[0] = d1_data; dat[1] = d3_data;
    idx[0] = d1_idx;  idx[1] = d3_idx;
    for (int d = 0; d < 2; d++) begin
      if (iv[d] && (!prev_iv[d] || ins[d] != prev_inst[d])) issue_cyc[d] = cyc;
      if (rv[d] && !prev_rv[d]) begin
        n_lat[d]++;
        if ((cyc - issue_cyc[d]) != ((d == 0) ? 1 : 3)) begin
          n_latbad[d]++;
          bad_lat[d] = cyc - issue_cyc[d];
        end
      end
      if (rv[d] && res_ready) begin
        got_data[d][n_got[d] % 512] = dat[d];
        got_idx[d][n_got[d] % 512]  = idx[d];
        n_got[d]++;
      end
      if (dn[d]) begin
        n_done[d]++;
        done_cyc[d] = cyc;
      end
      if (iv[d]) n_iv[d]++;
      if (rv[d]) n_rv[d]++;
      prev_rv[d]   = rv[d];
      prev_iv[d]   = iv[d];
      prev_inst[d] = ins[d];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_d1_flags"}, {28'h0, d1_busy, d1_done, d1_iv, d1_rv}, 32'h0);
    chk({tag, "_d1_inst"},  {12'h0, d1_inst}, 32'h0);
    chk({tag, "_d1_data"},  d1_data, 32'h0);
    chk({tag, "_d1_idx"},   {28'h0, d1_idx}, 32'h0);
    chk({tag, "_d3_flags"}, {28'h0, d3_busy, d3_done, d3_iv, d3_rv}, 32'h0);
    chk({tag, "_d3_inst"},  {12'h0, d3_inst}, 32'h0);
    chk({tag, "_d3_data"},  d3_data, 32'h0);
    chk({tag, "_d3_idx"},   {28'h0, d3_idx}, 32'h0);
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (i == 0)      model_mem[i] = 20'h48803;
      else if (i == 1) model_mem[i] = 20'h4AC03;
      else             model_mem[i] = INST_W'(32'h10000 + 32'(i) * 32'h1111);
      load_we   = 1'b1;
      load_addr = AW'(i);
      load_data = model_mem[i];
    end
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // One program run with optional backpressure on bp_idx and optional perturbation
  task automatic run_vec(input int len, input int bp_idx, input bit perturb,
                         input int exp_n, input string tag);
    int b_got[2], b_done[2], b_lat[2], b_bad[2], b_iv[2], b_rv[2];
    int s_cyc, k, bp_left, tail;
    bit bp_used, seen1;
    logic [RES_W-1:0]  h_data;
    logic [AW-1:0]     h_idx;
    logic [INST_W-1:0] h_inst;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      b_got[d] = n_got[d]; b_done[d] = n_done[d]; b_lat[d] = n_lat[d];
      b_bad[d] = n_latbad[d]; b_iv[d] = n_iv[d]; b_rv[d] = n_rv[d];
    end
    prog_len = (AW+1)'(len);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_cyc = cyc;
    if (exp_n > 0) begin
      chk({tag, "_first_inst_d1"}, {12'h0, d1_inst}, {12'h0, model_mem[0]});
      chk({tag, "_first_inst_d3"}, {12'h0, d3_inst}, {12'h0, model_mem[0]});
      chk({tag, "_busy_iv"}, {28'h0, d1_busy, d1_iv, d3_busy, d3_iv}, 32'hF);
    end else begin
      chk({tag, "_done_now"}, {30'h0, d1_done, d3_done}, 32'h3);
    end
    bp_left = 0; bp_used = 1'b0; seen1 = 1'b0; k = 0; tail = -1;
    while (k < 3000 && tail != 0) begin
      start   = 1'b0;
      load_we = 1'b0;
      if (perturb && k < 3) begin
        start     = 1'b1;
        load_we   = 1'b1;
        load_addr = AW'(k + 1);
        load_data = 20'hDEAD0;
      end
      if (perturb && d1_done && !seen1) start = 1'b1;
      if (d1_done) seen1 = 1'b1;
      if (bp_left > 0) begin
        chk({tag, "_hold_rv"},   {31'h0, d1_rv}, 32'h1);
        chk({tag, "_hold_data"}, d1_data, h_data);
        chk({tag, "_hold_idx"},  {28'h0, d1_idx}, {28'h0, h_idx});
        chk({tag, "_hold_inst"}, {12'h0, d1_inst}, {12'h0, h_inst});
        bp_left--;
        if (bp_left == 0) res_ready = 1'b1;
      end else if (bp_idx >= 0 && !bp_used && d1_rv && d1_idx == AW'(bp_idx)) begin
        res_ready = 1'b0;
        bp_used   = 1'b1;
        bp_left   = 5;
        h_data = d1_data; h_idx = d1_idx; h_inst = d1_inst;
      end
      if (tail > 0) tail--;
      else if (tail < 0 && n_done[0] > b_done[0] && n_done[1] > b_done[1]) tail = 6;
      @(negedge clk);
      k++;
    end
    start = 1'b0; load_we = 1'b0; res_ready = 1'b1;
    checks++;
    if (tail != 0) begin
      failures++;
      $display("FAIL %s_timeout: got no done within %0d cycles, expected done", tag, k);
    end
    if (bp_idx >= 0) chk({tag, "_bp_seen"}, {31'h0, bp_used}, 32'h1);
    for (int d = 0; d < 2; d++) begin
      string p;
      p = $sformatf("%s_d%0d", tag, (d == 0) ? 1 : 3);
      chk({p, "_nres"}, n_got[d] - b_got[d], exp_n);
      for (int i = 0; i < exp_n && i < n_got[d] - b_got[d]; i++) begin
        chk($sformatf("%s_data%0d", p, i), got_data[d][(b_got[d] + i) % 512],
            {12'h0, model_mem[i]});
        chk($sformatf("%s_idx%0d", p, i), {28'h0, got_idx[d][(b_got[d] + i) % 512]}, i);
      end
      chk({p, "_ndone"}, n_done[d] - b_done[d], 1);
      chk({p, "_nlat"}, n_lat[d] - b_lat[d], exp_n);
      if (n_latbad[d] != b_bad[d])
        chk({p, "_latency"}, bad_lat[d], (d == 0) ? 1 : 3);
      else
        chk({p, "_latbad"}, n_latbad[d] - b_bad[d], 0);
      if (exp_n == 0) begin
        chk({p, "_iv_cycles"}, n_iv[d] - b_iv[d], 0);
        chk({p, "_rv_cycles"}, n_rv[d] - b_rv[d], 0);
        chk({p, "_done_cyc"}, done_cyc[d], s_cyc);
      end
    end
    chk({tag, "_idle_flags"}, {26'h0, d1_busy, d1_iv, d1_rv, d3_busy, d3_iv, d3_rv}, 32'h0);
    if (exp_n > 0) begin
      chk({tag, "_last_inst_d1"}, {12'h0, d1_inst}, {12'h0, model_mem[exp_n - 1]});
      chk({tag, "_last_inst_d3"}, {12'h0, d3_inst}, {12'h0, model_mem[exp_n - 1]});
    end
  endtask

  typedef struct {
    int len;
    int bp_idx;
    bit perturb;
    int exp_n;
  } vec_t;

  initial begin
    vec_t vecs[7];
    string tags[7];
    bit found;
    vecs[0] = '{len: 2,  bp_idx: -1, perturb: 1'b0, exp_n: 2};   tags[0] = "basic";
    vecs[1] = '{len: 3,  bp_idx: 1,  perturb: 1'b0, exp_n: 3};   tags[1] = "backpressure";
    vecs[2] = '{len: 0,  bp_idx: -1, perturb: 1'b0, exp_n: 0};   tags[2] = "empty";
    vecs[3] = '{len: 16, bp_idx: -1, perturb: 1'b0, exp_n: 16};  tags[3] = "full";
    vecs[4] = '{len: 17, bp_idx: -1, perturb: 1'b0, exp_n: 16};  tags[4] = "clamp17";
    vecs[5] = '{len: 31, bp_idx: -1, perturb: 1'b0, exp_n: 16};  tags[5] = "clamp31";
    vecs[6] = '{len: 4,  bp_idx: -1, perturb: 1'b1, exp_n: 4};   tags[6] = "ignored";

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    load_prog();

    for (int v = 0; v < 7; v++)
      run_vec(vecs[v].len, vecs[v].bp_idx, vecs[v].perturb, vecs[v].exp_n, tags[v]);

    // Abort during WAIT of entry 2, then rerun from entry 0 with memory retained
    @(negedge clk);
    prog_len = 5'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (d1_iv && d1_inst == model_mem[2] && !d1_rv) found = 1'b1;
      else @(negedge clk);
    end
    chk("midrun_reached_idx2", {31'h0, found}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_vec(4, -1, 1'b0, 4, "rerun");

`ifdef INST_SEQ_STEP_MODE_EN
    step = 1'b0;
    @(negedge clk);
    prog_len = 5'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (d1_rv && d1_idx == '0) found = 1'b1;
      else @(negedge clk);
    end
    chk("step_idx0_valid", {31'h0, found}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("step_hold_inst", {12'h0, d1_inst}, {12'h0, model_mem[0]});
      chk("step_hold_flags", {29'h0, d1_iv, d1_rv, d1_busy}, 32'h5);
    end
    step  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!d1_busy && !d3_busy) found = 1'b1;
    end
    chk("step_run_finished", {31'h0, found}, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got time %0t, expected finish earlier", $time);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/inst_seq_ctrl.md
Name: inst_seq_ctrl

Overview:
- Program sequencer for the combinational instruction datapath (20-bit `instruccion` in, 32-bit ALU result out).
- Holds a small program buffer loaded by a host and issues its entries one at a time to the datapath.
- Waits a fixed datapath latency, captures each result and hands it out over a valid/ready port.
- Sits between the host/test harness and the datapath; it is the only driver of `instruccion`.

Parameters:
- DEPTH, 16, number of program entries (power of 2).
- AW, 4, address width, equal to log2(DEPTH).
- LAT, 1, cycles from an `instruccion` update to a valid `alu_result`; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load_we  in  1  program write strobe.
- load_addr  in  AW  program write address.
- load_data  in  20  instruction word to write.
- prog_len  in  AW+1  number of entries to run, 0..DEPTH; sampled on start.
- start  in  1  single-cycle run request.
- step  in  1  advance request; present only with STEP_MODE_EN.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- instruccion  out  20  instruction to the datapath.
- inst_valid  out  1  `instruccion` is a live program entry.
- alu_result  in  32  datapath result.
- res_valid  out  1  result available.
- res_data  out  32  captured result.
- res_idx  out  AW  program index of res_data.
- res_ready  in  1  result consumer ready.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; pc, cnt, len cleared.
- Reset values: busy, done, inst_valid, res_valid all 0; instruccion, res_data, res_idx all 0.
- Program memory is not reset and keeps its contents across rst_n.
- States: IDLE, WAIT, OUT, HOLD (HOLD only with STEP_MODE_EN), DONE.
- IDLE:
  - load_we writes mem[load_addr].
  - start with prog_len!=0: on that edge latch len=prog_len, pc=0, instruccion<=mem[0], inst_valid<=1, busy<=1, cnt<=LAT-1; go to WAIT.
  - start with prog_len==0: go to DONE; no instruction is issued.
- WAIT:
  - cnt decrements each cycle.
  - On the edge where cnt==0: res_data<=alu_result, res_idx<=pc, res_valid<=1; go to OUT.
- OUT:
  - Hold res_valid, res_data and res_idx until res_valid&res_ready.
  - On handshake, res_valid<=0, then:
  - If pc==len-1: inst_valid<=0; go to DONE.
  - Otherwise: pc<=pc+1, instruccion<=mem[pc+1], cnt<=LAT-1; go to WAIT.
- DONE: done=1 for exactly one cycle, busy<=0; go to IDLE.
- instruccion stays stable from issue until the next issue; after a run it holds the last entry, with inst_valid=0.
- Latency:
  - First instruccion appears 1 edge after start is sampled.
  - res_valid rises LAT edges after the matching instruccion update.
  - With res_ready=1, throughput is one result per LAT+1 cycles.
- Ignored inputs: start while busy or in DONE; load_we while busy.
- The pc never wraps. len==DEPTH runs indices 0..DEPTH-1 and then stops.
- prog_len>DEPTH is clamped to DEPTH.
- rst_n asserted mid-run aborts immediately. No done pulse is generated, and no partial result remains visible.

Optional Feature:
- Macro: INST_SEQ_STEP_MODE_EN.
- Defined:
  - `step` port exists.
  - A result handshake that is not the last goes to HOLD, with inst_valid=1 and instruccion unchanged.
  - The next entry is issued only on the edge where step==1.
  - The first entry is still issued directly by start.
  - step in any other state is ignored.
- Undefined: no step port and no HOLD state; runs are free-running as described above.

Decomposition:
- Package inst_seq_pkg:
  - INST_W=20, RES_W=32.
  - State enum.
  - Field localparams OP[19:18], DST[17:13], FN[12:10], SRA[9:5], SRB[4:0], for debug and assertions.
- Sub-module inst_seq_pmem: DEPTH x 20 register array with one synchronous write port and one asynchronous read port.

Test Plan:
- Basic run. Setup: mem[0]=20'h48803, mem[1]=20'h4AC03, prog_len=2, LAT=1, res_ready=1, datapath model alu_result={12'h0,instruccion}; pulse start.
  - Required: instruccion=20'h48803 next cycle.
  - Required: res_data=32'h00048803/idx0, then 32'h0004AC03/idx1.
  - Required: one done pulse, then busy=0, exactly 2 results.
- Backpressure: hold res_ready=0 for 5 cycles in OUT.
  - Required: res_valid, res_data, res_idx and instruccion held, pc unchanged, no result lost.
- Empty program: prog_len=0, start.
  - Required: done one cycle later; inst_valid and res_valid stay 0.
- Full depth: prog_len=16, LAT=3.
  - Required: 16 results, idx 0..15, each res_valid 3 edges after issue, no wrap, done after idx 15.
- Reset mid-run: rst_n low during WAIT of idx 2.
  - Required: all outputs 0 immediately.
  - Required: after release, start reruns from idx 0 with memory retained.
- Ignored inputs: start and load_we toggled while busy.
  - Required: results identical to an unperturbed run.
  - Required with INST_SEQ_STEP_MODE_EN: no idx1 issue until step=1.
